// File: rtl/ram_ctrl_pkg.sv
// Shared widths and FSM state encoding for the RAM access controller.
package ram_ctrl_pkg;

    localparam int ADDR_W = 4;
    localparam int DATA_W = 2;
    localparam int DEPTH  = 16;

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_WRITE      = 3'd1,
        ST_READ_ADDR  = 3'd2,
        ST_READ_LATCH = 3'd3,
        ST_CLEAR      = 3'd4
    } state_t;

endpackage

// File: rtl/key_debounce.sv
// Push-button conditioner: two-flop synchronizer, stability counter and a
// one-cycle press pulse on each accepted rising level.
module key_debounce #(
    parameter int DEBOUNCE_CYCLES = 250000
) (
    input  logic clk,
    input  logic rst,
    input  logic key,
    output logic press
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_DONE = CNT_W'(DEBOUNCE_CYCLES);

    logic             sync1_r;
    logic             sync2_r;
    logic             level_r;
    logic             press_r;
    logic [CNT_W-1:0] cnt_r;

    // Synchronize, then accept a new level only after it has held for the full window.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_r <= 1'b0;
            sync2_r <= 1'b0;
            level_r <= 1'b0;
            press_r <= 1'b0;
            cnt_r   <= '0;
        end else begin
            sync1_r <= key;
            sync2_r <= sync1_r;
            press_r <= 1'b0;
            if (sync2_r == level_r) begin
                cnt_r <= '0;
            end else if (cnt_r == CNT_DONE) begin
                cnt_r   <= '0;
                level_r <= sync2_r;
                press_r <= sync2_r;
            end else begin
                cnt_r <= cnt_r + CNT_W'(1);
            end
        end
    end

    assign press = press_r;

endmodule

// File: rtl/ram_access_ctrl.sv
// Key-driven sequencer producing registered write, read and clear controls
// for the 16x2 dual-port RAM display stage.
module ram_access_ctrl
    import ram_ctrl_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 250000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              key_wr,
    input  logic              key_rd,
    input  logic              key_clr,
    input  logic [DATA_W-1:0] sw_data,
    output logic              en,
    output logic              we,
    output logic [ADDR_W-1:0] inaddr,
    output logic [ADDR_W-1:0] outaddr,
    output logic [DATA_W-1:0] din,
    output logic              busy,
    output logic [ADDR_W-1:0] wr_ptr,
    output logic [ADDR_W-1:0] rd_ptr
);

    logic press_wr_s, press_rd_s, press_clr_s;

    key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_wr  (.clk(clk), .rst(rst), .key(key_wr),  .press(press_wr_s));
    key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_rd  (.clk(clk), .rst(rst), .key(key_rd),  .press(press_rd_s));
    key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_clr (.clk(clk), .rst(rst), .key(key_clr), .press(press_clr_s));

    state_t            state_r, state_s;
    logic              en_r, en_s, we_r, we_s, busy_r;
    logic [ADDR_W-1:0] inaddr_r, inaddr_s, outaddr_r, outaddr_s;
    logic [ADDR_W-1:0] wr_ptr_r, wr_ptr_s, rd_ptr_r, rd_ptr_s, clr_cnt_r, clr_cnt_s;
    logic [DATA_W-1:0] din_r, din_s;

    // Next state and next output values; outputs are registered alongside the state.
    always_comb begin
        state_s   = state_r;
        en_s      = 1'b0;
        we_s      = 1'b0;
        din_s     = '0;
        inaddr_s  = inaddr_r;
        outaddr_s = outaddr_r;
        wr_ptr_s  = wr_ptr_r;
        rd_ptr_s  = rd_ptr_r;
        clr_cnt_s = clr_cnt_r;
        case (state_r)
            ST_IDLE: begin
                if (press_clr_s) begin
                    state_s   = ST_CLEAR;
                    en_s      = 1'b1;
                    we_s      = 1'b1;
                    inaddr_s  = '0;
                    clr_cnt_s = '0;
                end else if (press_wr_s) begin
                    state_s  = ST_WRITE;
                    en_s     = 1'b1;
                    we_s     = 1'b1;
                    inaddr_s = wr_ptr_r;
                    din_s    = sw_data;
                end else if (press_rd_s) begin
                    state_s   = ST_READ_ADDR;
                    outaddr_s = rd_ptr_r;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_WRITE: begin
                state_s  = ST_IDLE;
                wr_ptr_s = wr_ptr_r + ADDR_W'(1);
            end
            ST_READ_ADDR: begin
                // RAM has registered outaddr; data is valid during the latch cycle.
                state_s = ST_READ_LATCH;
                en_s    = 1'b1;
            end
            ST_READ_LATCH: begin
                state_s  = ST_IDLE;
                rd_ptr_s = rd_ptr_r + ADDR_W'(1);
            end
            ST_CLEAR: begin
                if (clr_cnt_r == LAST_ADDR) begin
                    state_s  = ST_IDLE;
                    wr_ptr_s = '0;
                    rd_ptr_s = '0;
                end else begin
                    clr_cnt_s = clr_cnt_r + ADDR_W'(1);
                    en_s      = 1'b1;
                    we_s      = 1'b1;
                    inaddr_s  = clr_cnt_r + ADDR_W'(1);
                end
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // State, pointer and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r   <= ST_IDLE;
            en_r      <= 1'b0;
            we_r      <= 1'b0;
            busy_r    <= 1'b0;
            din_r     <= '0;
            inaddr_r  <= '0;
            outaddr_r <= '0;
            wr_ptr_r  <= '0;
            rd_ptr_r  <= '0;
            clr_cnt_r <= '0;
        end else begin
            state_r   <= state_s;
            en_r      <= en_s;
            we_r      <= we_s;
            busy_r    <= (state_s != ST_IDLE);
            din_r     <= din_s;
            inaddr_r  <= inaddr_s;
            outaddr_r <= outaddr_s;
            wr_ptr_r  <= wr_ptr_s;
            rd_ptr_r  <= rd_ptr_s;
            clr_cnt_r <= clr_cnt_s;
        end
    end

    assign en      = en_r;
    assign we      = we_r;
    assign din     = din_r;
    assign inaddr  = inaddr_r;
    assign outaddr = outaddr_r;
    assign busy    = busy_r;
    assign wr_ptr  = wr_ptr_r;
    assign rd_ptr  = rd_ptr_r;

endmodule

// File: doc/ram_access_ctrl.md
# ram_access_ctrl

Upstream sequencer for the 16×2-bit dual-port RAM display stage. It turns three raw push-buttons and two data switches into the stage's `en`, `we`, `inaddr`, `outaddr` and `din` controls:

- **Write key:** stores the switch value at an auto-incrementing write pointer.
- **Read key:** presents the next read address and then asserts the read-latch strobe once RAM data is valid.
- **Clear key:** zero-fills all 16 words.

## Interface
- `DEBOUNCE_CYCLES`, default 250000: cycles a key level must hold stable before it is accepted (5 ms at 50 MHz). Set to 4 in simulation.
- `clk`  in  1  system clock; all logic on the rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `key_wr`  in  1  raw write button, asynchronous, high = pressed.
- `key_rd`  in  1  raw read button, asynchronous, high = pressed.
- `key_clr`  in  1  raw clear button, asynchronous, high = pressed.
- `sw_data`  in  2  data switches, sampled in the cycle the WRITE state is entered.
- `en`  out  1  RAM stage enable.
- `we`  out  1  write enable.
  - `en & we` = RAM write.
  - `en & !we` = display latch.
- `inaddr`  out  4  write address.
- `outaddr`  out  4  read address.
- `din`  out  2  write data.
- `busy`  out  1  high while not in IDLE.
- `wr_ptr`  out  4  next write address, for LEDs.
- `rd_ptr`  out  4  next read address, for LEDs.

## Operation
- Each key passes through `key_debounce`:
  - two-flop synchronizer;
  - stability counter;
  - one-cycle `press` pulse on each accepted 0→1 transition.
- A press is generated only after release and re-press. Holding a key yields exactly one pulse.
- FSM states: IDLE, WRITE, READ_ADDR, READ_LATCH, CLEAR.
- From IDLE, on a press pulse:
  - clear → CLEAR;
  - else write → WRITE;
  - else read → READ_ADDR.
- Simultaneous pulses in the same cycle are resolved by the same priority: clr > wr > rd. Lower-priority pulses in that cycle are dropped.
- Press pulses arriving while `busy` = 1 are discarded, not queued.
- **WRITE** (1 cycle):
  - outputs `en`=1, `we`=1, `inaddr`=`wr_ptr`, `din`=`sw_data` (registered on entry);
  - on exit, `wr_ptr` increments mod 16 (15→0);
  - returns to IDLE.
- **READ_ADDR** (1 cycle):
  - `outaddr`=`rd_ptr`, `en`=0, `we`=0;
  - gives the RAM one edge to register the address.
- **READ_LATCH** (1 cycle):
  - `en`=1, `we`=0, `outaddr` held;
  - on exit, `rd_ptr` increments mod 16;
  - returns to IDLE.
- **CLEAR** (16 cycles):
  - uses an internal 4-bit counter c = 0..15;
  - each cycle: `en`=1, `we`=1, `inaddr`=c, `din`=0;
  - after c=15: `wr_ptr`=0, `rd_ptr`=0, return to IDLE.
- In IDLE: `en`=0, `we`=0, `din`=0. `inaddr` and `outaddr` hold their last values, so the read port never glitches.
- The address width is 4 bits and every pointer wraps naturally. There is no full/empty notion; overwriting is allowed.

## Timing
- All outputs are registered.
- Reset values:
  - `en`=0, `we`=0, `din`=0;
  - `inaddr`=0, `outaddr`=0;
  - `wr_ptr`=0, `rd_ptr`=0;
  - `busy`=0;
  - FSM=IDLE;
  - debounce counters and synchronizers cleared.
- Key-to-press latency: 2 synchronizer cycles + `DEBOUNCE_CYCLES` + 1.
- Press pulse at edge k:
  - WRITE outputs are visible k+1..k+2;
  - READ_ADDR is visible k+1..k+2;
  - READ_LATCH is visible k+2..k+3;
  - CLEAR is visible for k+1..k+17.
- The downstream display registers capture valid RAM data at the end of READ_LATCH. This relies on a single registered-address read latency.
- Write followed immediately by a read to the same address is safe: the FSM inserts ≥1 IDLE cycle between operations.
- A reset asserted mid-CLEAR or mid-WRITE drops `en`/`we` to 0 immediately (asynchronously). A partially cleared RAM is acceptable.

## Structure
- Package `ram_ctrl_pkg`:
  - `ADDR_W`=4, `DATA_W`=2, `DEPTH`=16;
  - FSM state encoding constants.
- Sub-module `key_debounce`:
  - parameter `DEBOUNCE_CYCLES`;
  - ports `clk`, `rst`, `key`, `press`;
  - instantiated three times.
- The top level holds the FSM, the pointers and the clear counter.

## Test plan
- **Reset/idle:** assert `rst` mid-run, then release.
  - All outputs read 0.
  - `en` stays 0 with no key activity.
- **Write + wrap:** `sw_data`=2'b10, press `key_wr` 17 times.
  - 17 single-cycle `en`=`we`=1 pulses at `inaddr` 0,1,…,15,0, each with `din`=2.
  - `wr_ptr` ends at 1.
- **Read timing:** after writes, press `key_rd`.
  - `outaddr`=0 with `en`=0 for one cycle, then `en`=1, `we`=0 for one cycle.
  - `rd_ptr`=1.
  - Against a RAM model, the display latches the stored value.
- **Bounce rejection:** with `DEBOUNCE_CYCLES`=4, `key_wr` toggles every 2 cycles for 20 cycles, then holds high for 50 cycles.
  - Exactly one write.
- **Clear + priority:** `key_clr` and `key_wr` press pulses in the same cycle.
  - 16 consecutive writes of 0 to addresses 0..15.
  - No data write occurs; `wr_ptr`=`rd_ptr`=0 afterwards.
  - A `key_rd` press during CLEAR is ignored.
- **Reset mid-CLEAR:** assert `rst` at CLEAR cycle 7.
  - `en`/`we` drop to 0 without waiting for a clock edge.
  - FSM returns to IDLE.
